// File: rtl/res_arb_pkg.sv
// Shared types and constants for the result-RAM arbiter: FSM state, default
// RAM geometry and the requester-id width helper.
package res_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int RES_AW = 14;
    localparam int RES_DW = 8;

    // Width of a requester id; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/res_arb_rr_pick.sv
// Combinational round-robin picker: first asserted vld_i at or after ptr_i,
// searching upward with wrap.
module res_arb_rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vld_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] id_o,
    output logic          any_o
);

    always_comb begin
        int idx;
        gnt_o = '0;
        id_o  = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!any_o && vld_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/res_mem_arbiter.sv
// Round-robin arbiter with locked sequences for the single-port result RAM.
// Optional lock watchdog enabled by defining RES_ARB_LOCK_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no owner, round-robin among all requesters
// LOCKED | only lock_id_q may be granted, rr_ptr frozen
module res_mem_arbiter
    import res_arb_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = RES_AW,
    parameter int DW       = RES_DW,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_vld,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_gnt,
    output logic [NREQ-1:0]    rsp_vld,
    output logic [DW-1:0]      rsp_data,
    output logic               res_rd,
    output logic               res_wr,
    output logic [AW-1:0]      res_addr,
    output logic [DW-1:0]      res_do,
    input  logic [DW-1:0]      res_di,
    output logic               lock_err
);

    localparam int IDW = clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || RD_LAT < 1 || RD_LAT > 3 || LOCK_MAX < 1) begin : g_bad_cfg
        $error("res_mem_arbiter: unsupported parameter set");
    end

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   lock_id_q, lock_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             res_rd_q, res_wr_q;
    logic [AW-1:0]    res_addr_q;
    logic [DW-1:0]    res_do_q;
    logic [IDW-1:0]   iss_id_q;
    logic [RD_LAT-1:0] pv_q;
    logic [IDW-1:0]   pid_q [RD_LAT];

    logic [NREQ-1:0]  owner_mask, pick_vld, pick_gnt;
    logic [IDW-1:0]   win_id;
    logic             win_any;
    logic             timeout;

    function automatic logic [IDW-1:0] nxt_id(input logic [IDW-1:0] id);
        return (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
    endfunction

    always_comb begin
        owner_mask = '0;
        for (int i = 0; i < NREQ; i++) owner_mask[i] = (lock_id_q == IDW'(i));
        pick_vld = (state_q == LOCKED) ? (req_vld & owner_mask) : req_vld;
    end

    res_arb_rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
        .vld_i (pick_vld),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .id_o  (win_id),
        .any_o (win_any)
    );

`ifdef RES_ARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;

    // Counts owner-idle cycles; timeout fires on the LOCK_MAX-th one.
    always_comb begin
        idle_cnt_d = '0;
        timeout    = 1'b0;
        if (state_q == LOCKED && !(|(req_vld & owner_mask))) begin
            if (idle_cnt_q == CW'(LOCK_MAX - 1)) timeout = 1'b1;
            else idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) idle_cnt_q <= '0;
        else        idle_cnt_q <= idle_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    rr_ptr_d = nxt_id(win_id);
                    if (req_lock[win_id]) begin
                        state_d   = LOCKED;
                        lock_id_d = win_id;
                    end
                end
            end
            LOCKED: begin
                if (win_any) begin
                    if (!req_lock[win_id]) state_d = IDLE;
                end else if (timeout) begin
                    state_d  = IDLE;
                    rr_ptr_d = nxt_id(lock_id_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_gnt  = reset ? pick_gnt : '0;
        lock_err = reset & timeout;
        rsp_vld  = '0;
        rsp_data = '0;
        if (pv_q[RD_LAT-1]) begin
            rsp_data = res_di;
            for (int i = 0; i < NREQ; i++) rsp_vld[i] = (pid_q[RD_LAT-1] == IDW'(i));
        end
    end

    // RAM pins and the {valid, id} return pipe; reset drops reads in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_rd_q   <= 1'b0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
            res_do_q   <= '0;
            iss_id_q   <= '0;
            pv_q       <= '0;
            for (int k = 0; k < RD_LAT; k++) pid_q[k] <= '0;
        end else begin
            res_rd_q <= win_any & ~req_we[win_id];
            res_wr_q <= win_any & req_we[win_id];
            if (win_any) begin
                res_addr_q <= req_addr[int'(win_id)*AW +: AW];
                res_do_q   <= req_wdata[int'(win_id)*DW +: DW];
                iss_id_q   <= win_id;
            end
            pv_q[0]  <= res_rd_q;
            pid_q[0] <= iss_id_q;
            for (int k = 1; k < RD_LAT; k++) begin
                pv_q[k]  <= pv_q[k-1];
                pid_q[k] <= pid_q[k-1];
            end
        end
    end

    assign res_rd   = res_rd_q;
    assign res_wr   = res_wr_q;
    assign res_addr = res_addr_q;
    assign res_do   = res_do_q;

endmodule

// File: tb/tb_res_mem_arbiter.sv
// Self-checking bench for res_mem_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model and a behavioural RAM.
module tb_res_mem_arbiter;

    localparam int NREQ = 3, AW = 14, DW = 8, RD_LAT = 1, LOCK_MAX = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic [NREQ-1:0]    req_vld, req_we, req_lock, req_gnt, rsp_vld;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]      rsp_data, res_do, res_di;
    logic               res_rd, res_wr, lock_err;
    logic [AW-1:0]      res_addr;

    res_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset), .req_vld(req_vld), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_gnt(req_gnt), .rsp_vld(rsp_vld),
        .rsp_data(rsp_data), .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr),
        .res_do(res_do), .res_di(res_di), .lock_err(lock_err)
    );

    // Unwritten locations read as addr[7:0]^0x84 (so 0x0081 holds 0x05).
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h84;
    endfunction

    bit [DW-1:0] ram [1<<AW];
    bit          ram_wr [1<<AW];
    bit [DW-1:0] ram_pipe [RD_LAT];
    always @(posedge clk) begin
        if (res_wr) begin
            ram[res_addr]    <= res_do;
            ram_wr[res_addr] <= 1'b1;
        end
        for (int k = 1; k < RD_LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
        ram_pipe[0] <= res_rd ? (ram_wr[res_addr] ? ram[res_addr] : init_val(res_addr)) : 8'h00;
    end
    assign res_di = ram_pipe[RD_LAT-1];

    int n_err = 0, n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = none), pointer, idle count, expected pins.
    typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
    rsp_t        rq[$];
    bit [DW-1:0] mem_m [1<<AW];
    bit          mem_w [1<<AW];
    int          m_owner = -1, m_ptr = 0, m_idle = 0, cyc = 0, dut_win;
    bit          e_rd = 0, e_wr = 0, after_rst = 1;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_do = '0;

    bit            rst_drv = 0;
    bit            pend [NREQ], p_we [NREQ], p_lock [NREQ];
    logic [AW-1:0] p_addr [NREQ];
    logic [DW-1:0] p_wd [NREQ];

    task automatic step();
        int ewin;
        logic [NREQ-1:0] egnt, ersp;
        bit elerr;
        @(posedge clk);
        #1;
        reset = rst_drv;
        for (int i = 0; i < NREQ; i++) begin
            req_vld[i]  = pend[i];
            req_we[i]   = p_we[i];
            req_lock[i] = p_lock[i];
            req_addr[i*AW +: AW]  = p_addr[i];
            req_wdata[i*DW +: DW] = p_wd[i];
        end
        @(negedge clk);
        ewin = -1;
        if (rst_drv) begin
            if (m_owner >= 0) begin
                if (pend[m_owner]) ewin = m_owner;
            end else begin
                for (int k = 0; k < NREQ; k++)
                    if (ewin < 0 && pend[(m_ptr + k) % NREQ]) ewin = (m_ptr + k) % NREQ;
            end
        end
        egnt = '0;
        if (ewin >= 0) egnt[ewin] = 1'b1;
        elerr = 1'b0;
`ifdef RES_ARB_LOCK_TIMEOUT_EN
        elerr = rst_drv && m_owner >= 0 && ewin < 0 && (m_idle + 1 == LOCK_MAX);
`endif
        ersp = '0;
        if (rq.size() > 0 && rq[0].due == cyc) ersp[rq[0].id] = 1'b1;
        chk("gnt", 32'(req_gnt), 32'(egnt));
        chk("res_rd", 32'(res_rd), 32'(e_rd));
        chk("res_wr", 32'(res_wr), 32'(e_wr));
        chk("res_addr", 32'(res_addr), 32'(e_addr));
        chk("res_do", 32'(res_do), 32'(e_do));
        chk("rsp_vld", 32'(rsp_vld), 32'(ersp));
        if (ersp != 0) chk("rsp_data", 32'(rsp_data), 32'(rq[0].data));
        if (after_rst) chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("lock_err", 32'(lock_err), 32'(elerr));
        dut_win = -1;
        for (int i = 0; i < NREQ; i++) if (req_gnt[i]) dut_win = i;
        after_rst = !rst_drv;
        if (!rst_drv) begin
            m_owner = -1; m_ptr = 0; m_idle = 0;
            e_rd = 0; e_wr = 0; e_addr = '0; e_do = '0;
            rq.delete();
        end else begin
            if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
            e_rd = 0; e_wr = 0;
            if (ewin >= 0) begin
                e_rd = !p_we[ewin]; e_wr = p_we[ewin];
                e_addr = p_addr[ewin]; e_do = p_wd[ewin];
                if (p_we[ewin]) begin
                    mem_m[p_addr[ewin]] = p_wd[ewin];
                    mem_w[p_addr[ewin]] = 1'b1;
                end else begin
                    rq.push_back('{cyc + 1 + RD_LAT, ewin,
                                   mem_w[p_addr[ewin]] ? mem_m[p_addr[ewin]] : init_val(p_addr[ewin])});
                end
                if (m_owner < 0) begin
                    m_ptr = (ewin + 1) % NREQ;
                    if (p_lock[ewin]) m_owner = ewin;
                end else if (!p_lock[ewin]) begin
                    m_owner = -1;
                end
                m_idle = 0;
                pend[ewin] = 0;
            end else if (m_owner >= 0) begin
`ifdef RES_ARB_LOCK_TIMEOUT_EN
                m_idle++;
                if (m_idle == LOCK_MAX) begin
                    m_ptr = (m_owner + 1) % NREQ;
                    m_owner = -1;
                    m_idle = 0;
                end
`endif
            end
        end
        cyc++;
    endtask

    task automatic set_req(input int i, input bit we, input bit lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i] = 1; p_we[i] = we; p_lock[i] = lk; p_addr[i] = a; p_wd[i] = d;
    endtask

    task automatic do_reset(input int n);
        rst_drv = 0;
        repeat (n) step();
        rst_drv = 1;
    endtask

    task automatic drain(input int n);
        repeat (n) step();
    endtask

    initial begin
        int exp_rr [6];
        int exp_lk [7];
        int b, n;
        bit seen;
        exp_rr = '{0, 1, 2, 0, 1, 2};
        exp_lk = '{1, 1, 1, 1, 1, 1, 2};
        reset = 1'b0; req_vld = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; p_we[i] = 0; p_lock[i] = 0; p_addr[i] = '0; p_wd[i] = '0;
        end

        do_reset(3);

        // single read of 0x0081
        set_req(0, 0, 0, 14'h0081, 8'h00);
        step(); chk("tp1_gnt", 32'(dut_win), 32'd0);
        step(); chk("tp1_rd", 32'(res_rd), 32'd1); chk("tp1_addr", 32'(res_addr), 32'h81);
        step(); chk("tp1_rsp", 32'(rsp_vld), 32'b001); chk("tp1_data", 32'(rsp_data), 32'h05);

        // three continuous readers from reset
        do_reset(2);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i]) set_req(i, 0, 0, AW'(16'h40 + i * 4 + k), 8'h00);
            step();
            chk("rr_order", 32'(dut_win), 32'(exp_rr[k]));
        end
        drain(6);

        // locked sequence by requester 1
        do_reset(2);
        b = 0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin
                if (!pend[0]) set_req(0, 0, 0, 14'h0010, 8'h00);
                if (!pend[2]) set_req(2, 0, 0, 14'h0020, 8'h00);
            end
            if (!pend[1] && b < 6) begin
                set_req(1, b == 5, b < 5, 14'h0102, 8'h03);
                b++;
            end
            step();
            chk("lock_order", 32'(dut_win), 32'(exp_lk[k]));
        end
        drain(6);
        set_req(0, 0, 0, 14'h0102, 8'h00);
        step(); step(); step();
        chk("lock_wr_rd", 32'(rsp_data), 32'h03);

        // reset one cycle after a read grant
        do_reset(2);
        set_req(0, 0, 0, 14'h0081, 8'h00);
        step();
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, AW'(16'h30 + i), 8'h00);
        rst_drv = 0;
        step();
        step(); chk("rst_drop", 32'(rsp_vld), 32'h0); chk("rst_rd", 32'(res_rd), 32'h0);
        rst_drv = 1;
        step(); chk("rst_first_gnt", 32'(dut_win), 32'd0);
        drain(6);

`ifdef RES_ARB_LOCK_TIMEOUT_EN
        do_reset(2);
        set_req(2, 0, 1, 14'h0011, 8'h00);
        step(); chk("to_lock_gnt", 32'(dut_win), 32'd2);
        set_req(0, 0, 0, 14'h0012, 8'h00);
        n = 0; seen = 0;
        while (!seen && n < 80) begin
            step();
            n++;
            if (lock_err) seen = 1;
        end
        chk("to_dist", 32'(n), 32'd31);
        step(); chk("to_next_gnt", 32'(dut_win), 32'd0);
        drain(4);
`endif

        // random traffic
        do_reset(2);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                            AW'($urandom_range(0, 31)), DW'($urandom_range(0, 255)));
            rst_drv = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_drv = 1;
        drain(8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
